// File: rtl/io_reg_responder_if.sv
// IO request bus between the core pipeline (master) and a register responder
// (slave). Signal names follow the core's port naming, seen from the responder.
//
// Handshake: a request transfers in the cycle where iIO_REQ=1 and oIO_BUSY=0;
// the master holds REQ/ORDER/RW/ADDR/DATA stable until that cycle. Reads
// return on a one-cycle oIO_VALID strobe with oIO_DATA, which is 0 otherwise.
// Writes return no strobe.
interface io_reg_responder_if;
   logic        iIO_REQ;
   logic        oIO_BUSY;
   logic [1:0]  iIO_ORDER;
   logic        iIO_RW;
   logic [31:0] iIO_ADDR;
   logic [31:0] iIO_DATA;
   logic        oIO_VALID;
   logic [31:0] oIO_DATA;

   modport master (
      output iIO_REQ,
      output iIO_ORDER,
      output iIO_RW,
      output iIO_ADDR,
      output iIO_DATA,
      input  oIO_BUSY,
      input  oIO_VALID,
      input  oIO_DATA
   );

   modport slave (
      input  iIO_REQ,
      input  iIO_ORDER,
      input  iIO_RW,
      input  iIO_ADDR,
      input  iIO_DATA,
      output oIO_BUSY,
      output oIO_VALID,
      output oIO_DATA
   );
endinterface

// File: rtl/io_reg_responder.sv
// Responder for the core's IO request bus. Executes one byte/halfword/word
// read or write at a time against a bank of REG_NUM 32-bit registers, with a
// fixed LATENCY from acceptance to the access cycle. Bad accesses (out of
// range, misaligned, ORDER=11) are dropped for writes, return zero for reads,
// and set a sticky error flag. Register contents are exported flat for
// peripheral logic.
module io_reg_responder #(
   parameter int          REG_NUM   = 8,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0100,
   parameter int          LATENCY   = 2
) (
   input  logic                    iCLOCK,
   input  logic                    iRESET_SYNC,
   io_reg_responder_if.slave       io,
   output logic                    oERROR,
   input  logic                    iERROR_CLR,
   output logic [32*REG_NUM-1:0]   oREG_FLAT,
   output logic [1:0]              state_dbg
);

   localparam int         IW     = $clog2(REG_NUM);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] ORD_BYTE = 2'b00;
   localparam logic [1:0] ORD_HALF = 2'b01;
   localparam logic [1:0] ORD_WORD = 2'b10;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q;
   logic        accept;

   logic [1:0]  ord_q;
   logic        rw_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;

   logic [31:0] regs [REG_NUM];
   logic        err_q;

   logic [31:0] offset;
   logic [1:0]  lane;
   logic [IW-1:0] idx;
   logic        in_range;
   logic        misaligned;
   logic        acc_err;
   logic [31:0] size_mask;
   logic [31:0] wr_mask;
   logic [31:0] wr_data;
   logic [31:0] cur_reg;
   logic [31:0] rd_data;
   logic        do_resp;

   // Next-state logic: IDLE accepts, WAIT burns the remaining latency, RESP is the access cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io.iIO_REQ && !busy_q) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         ST_WAIT: begin
            // The counter is decremented every WAIT cycle; reaching zero means
            // the next cycle is exactly LATENCY cycles after acceptance.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register, latency counter and registered BUSY.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Capture the request fields at acceptance; the bus may change afterwards.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         ord_q  <= 2'b11;
         rw_q   <= 1'b0;
         addr_q <= 32'h0;
         data_q <= 32'h0;
      end else if (accept) begin
         ord_q  <= io.iIO_ORDER;
         rw_q   <= io.iIO_RW;
         addr_q <= io.iIO_ADDR;
         data_q <= io.iIO_DATA;
      end
   end

   // Address decode, alignment check and lane-shifted data/mask for the latched request.
   always_comb begin
      offset     = addr_q - ADDR_BASE;
      // ADDR_BASE is word aligned, so the offset's low bits equal the address lane.
      lane       = offset[1:0];
      idx        = offset[IW+1:2];
      // Unsigned compare on the full address keeps addresses below the base
      // from wrapping into the register window.
      in_range   = (addr_q >= ADDR_BASE) && (offset[31:2] < 30'(REG_NUM));
      misaligned = 1'b0;
      size_mask  = 32'h0;
      case (ord_q)
         ORD_BYTE: begin
            size_mask = 32'h0000_00FF;
         end
         ORD_HALF: begin
            size_mask  = 32'h0000_FFFF;
            misaligned = lane[0];
         end
         ORD_WORD: begin
            size_mask  = 32'hFFFF_FFFF;
            misaligned = (lane != 2'b00);
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
      acc_err = !in_range || misaligned;
      wr_mask = size_mask << {lane, 3'b000};
      wr_data = data_q << {lane, 3'b000};
      cur_reg = (int'(idx) < REG_NUM) ? regs[idx] : 32'h0;
      rd_data = (cur_reg >> {lane, 3'b000}) & size_mask;
      do_resp = (state_q == ST_RESP);
   end

   // Register bank: good writes commit at the end of the RESP cycle.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         for (int k = 0; k < REG_NUM; k++) begin
            regs[k] <= 32'h0;
         end
      end else if (do_resp && !rw_q && !acc_err) begin
         regs[idx] <= (regs[idx] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   // Sticky error flag: a new error in RESP takes priority over a clear.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         err_q <= 1'b0;
      end else if (do_resp && acc_err) begin
         err_q <= 1'b1;
      end else if (iERROR_CLR) begin
         err_q <= 1'b0;
      end
   end

   // Read response is driven straight from the RESP state; data is forced to 0 off-strobe.
   always_comb begin
      io.oIO_VALID = do_resp && rw_q;
      io.oIO_DATA  = 32'h0;
      if (do_resp && rw_q && !acc_err) begin
         io.oIO_DATA = rd_data;
      end
   end

   assign io.oIO_BUSY = busy_q;
   assign oERROR      = err_q;
   assign state_dbg   = state_q;

   // Flat export: register k occupies bits [32k+31:32k].
   for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
      assign oREG_FLAT[32*k +: 32] = regs[k];
   end

endmodule

// File: tb/tb_io_reg_responder.sv
// Bench for io_reg_responder: a LATENCY=2 instance checked against a byte-
// addressed memory model with directed and random accesses, plus a LATENCY=1
// instance checked for its shorter timing.
module tb_io_reg_responder;

   localparam int          LAT  = 2;
   localparam int          NREG = 8;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic clk;
   logic rst;
   logic clr0, clr1;
   logic err0, err1;
   logic [32*NREG-1:0] flat0, flat1;
   logic [1:0] st0, st1;

   io_reg_responder_if bus0 ();
   io_reg_responder_if bus1 ();

   io_reg_responder #(.REG_NUM(NREG), .ADDR_BASE(BASE), .LATENCY(LAT)) dut (
      .iCLOCK(clk), .iRESET_SYNC(rst), .io(bus0), .oERROR(err0),
      .iERROR_CLR(clr0), .oREG_FLAT(flat0), .state_dbg(st0)
   );

   io_reg_responder #(.REG_NUM(NREG), .ADDR_BASE(BASE), .LATENCY(1)) dut_l1 (
      .iCLOCK(clk), .iRESET_SYNC(rst), .io(bus1), .oERROR(err1),
      .iERROR_CLR(clr1), .oREG_FLAT(flat1), .state_dbg(st1)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the register bank as a plain byte array plus the sticky flag.
   logic [7:0] mem [4*NREG];
   bit         m_err;
   int         n_pass  = 0;
   int         n_total = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4*NREG; i++) mem[i] = 8'h0;
      m_err = 1'b0;
   endtask

   function automatic bit model_bad(input logic [1:0] ord, input logic [31:0] addr);
      int unsigned nbytes;
      if (ord == 2'b11) return 1'b1;
      if (addr < BASE) return 1'b1;
      if ((addr - BASE) / 4 >= NREG) return 1'b1;
      nbytes = 1 << ord;
      if (addr % nbytes != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] ord, input logic [31:0] addr);
      logic [31:0] v;
      int unsigned off;
      v   = 32'h0;
      off = addr - BASE;
      for (int b = 0; b < (1 << ord); b++) v[8*b +: 8] = mem[off + b];
      return v;
   endfunction

   task automatic model_write(input logic [1:0] ord, input logic [31:0] addr, input logic [31:0] data);
      int unsigned off;
      off = addr - BASE;
      for (int b = 0; b < (1 << ord); b++) mem[off + b] = data[8*b +: 8];
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      f = '0;
      for (int i = 0; i < 4*NREG; i++) f[8*i +: 8] = mem[i];
      return f;
   endfunction

   // Driver: one access on the LATENCY=2 instance, checking every cycle until it completes.
   task automatic do_access(input logic [1:0] ord, input logic rw, input logic [31:0] addr,
                            input logic [31:0] data, input bit clr_in_resp);
      bit          bad;
      logic [31:0] exp_rd;
      bad    = model_bad(ord, addr);
      exp_rd = (rw && !bad) ? model_read(ord, addr) : 32'h0;
      @(negedge clk);
      check("busy_before_req", bus0.oIO_BUSY, 1'b0);
      bus0.iIO_REQ   = 1'b1;
      bus0.iIO_ORDER = ord;
      bus0.iIO_RW    = rw;
      bus0.iIO_ADDR  = addr;
      bus0.iIO_DATA  = data;
      @(negedge clk);
      bus0.iIO_REQ   = 1'b0;
      bus0.iIO_ADDR  = $urandom();
      bus0.iIO_DATA  = $urandom();
      bus0.iIO_ORDER = 2'($urandom_range(0, 3));
      for (int k = 1; k <= LAT; k++) begin
         if (k == LAT && clr_in_resp) clr0 = 1'b1;
         check("busy_in_flight", bus0.oIO_BUSY, 1'b1);
         check("valid_timing", bus0.oIO_VALID, (k == LAT) && rw);
         check("read_data", bus0.oIO_DATA, (k == LAT && rw) ? exp_rd : 32'h0);
         check("err_held", err0, m_err);
         @(negedge clk);
      end
      clr0 = 1'b0;
      if (!rw && !bad) model_write(ord, addr, data);
      if (bad) m_err = 1'b1;
      else if (clr_in_resp) m_err = 1'b0;
      check("busy_after", bus0.oIO_BUSY, 1'b0);
      check("valid_after", bus0.oIO_VALID, 1'b0);
      check("reg_flat", flat0, model_flat());
      check("err_after", err0, m_err);
   endtask

   task automatic clear_err();
      @(negedge clk);
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      m_err = 1'b0;
      check("err_cleared", err0, 1'b0);
   endtask

   initial begin
      logic [1:0]  r_ord;
      logic        r_rw;
      logic [31:0] r_addr;
      int          pick;

      // Reset.
      rst = 1'b1;
      clr0 = 1'b0;
      clr1 = 1'b0;
      bus0.iIO_REQ = 1'b0; bus0.iIO_ORDER = 2'b00; bus0.iIO_RW = 1'b0;
      bus0.iIO_ADDR = 32'h0; bus0.iIO_DATA = 32'h0;
      bus1.iIO_REQ = 1'b0; bus1.iIO_ORDER = 2'b00; bus1.iIO_RW = 1'b0;
      bus1.iIO_ADDR = 32'h0; bus1.iIO_DATA = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", bus0.oIO_BUSY, 1'b0);
      check("rst_valid", bus0.oIO_VALID, 1'b0);
      check("rst_data", bus0.oIO_DATA, 32'h0);
      check("rst_err", err0, 1'b0);
      check("rst_flat", flat0, '0);

      // Word write then read, byte/halfword merge and partial reads.
      do_access(2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 1'b0);
      check("reg1_word", flat0[63:32], 32'hDEAD_BEEF);
      do_access(2'b10, 1'b1, 32'h104, 32'h0, 1'b0);
      do_access(2'b00, 1'b0, 32'h107, 32'h0000_0012, 1'b0);
      do_access(2'b01, 1'b0, 32'h104, 32'h0000_ABCD, 1'b0);
      check("reg1_merged", flat0[63:32], 32'h12AD_ABCD);
      do_access(2'b00, 1'b1, 32'h106, 32'h0, 1'b0);
      do_access(2'b01, 1'b1, 32'h106, 32'h0, 1'b0);
      do_access(2'b00, 1'b1, 32'h107, 32'h0, 1'b0);

      // Errors: misaligned read, out-of-range write, below-base write with a same-cycle clear.
      do_access(2'b01, 1'b1, 32'h101, 32'h0, 1'b0);
      check("err_set_misaligned", err0, 1'b1);
      clear_err();
      do_access(2'b10, 1'b0, 32'h120, 32'hFFFF_FFFF, 1'b0);
      do_access(2'b10, 1'b0, 32'h0FC, 32'h1234_5678, 1'b1);
      check("err_set_beats_clr", err0, 1'b1);
      clear_err();
      do_access(2'b11, 1'b1, 32'h108, 32'h0, 1'b0);
      do_access(2'b10, 1'b0, 32'hFFFF_FF00, 32'hAAAA_5555, 1'b0);
      clear_err();

      // REQ held high: a read accepted every LATENCY+1 cycles.
      @(negedge clk);
      bus0.iIO_REQ = 1'b1; bus0.iIO_ORDER = 2'b10; bus0.iIO_RW = 1'b1; bus0.iIO_ADDR = 32'h104;
      for (int c = 0; c < 9; c++) begin
         check("held_valid", bus0.oIO_VALID, (c % (LAT + 1)) == LAT);
         check("held_busy", bus0.oIO_BUSY, (c % (LAT + 1)) != 0);
         check("held_data", bus0.oIO_DATA, ((c % (LAT + 1)) == LAT) ? 32'h12AD_ABCD : 32'h0);
         @(negedge clk);
      end
      bus0.iIO_REQ = 1'b0;
      repeat (LAT) @(negedge clk);
      check("held_idle", bus0.oIO_BUSY, 1'b0);

      // REQ pulse while busy is not executed.
      bus0.iIO_REQ = 1'b1; bus0.iIO_ORDER = 2'b10; bus0.iIO_RW = 1'b0;
      bus0.iIO_ADDR = 32'h108; bus0.iIO_DATA = 32'h1111_2222;
      @(negedge clk);
      bus0.iIO_ADDR = 32'h10C; bus0.iIO_DATA = 32'h3333_4444;
      @(negedge clk);
      bus0.iIO_REQ = 1'b0;
      @(negedge clk);
      model_write(2'b10, 32'h108, 32'h1111_2222);
      check("busy_pulse_ignored", flat0, model_flat());

      // Reset during WAIT drops the pending write.
      @(negedge clk);
      bus0.iIO_REQ = 1'b1; bus0.iIO_ORDER = 2'b10; bus0.iIO_RW = 1'b0;
      bus0.iIO_ADDR = 32'h100; bus0.iIO_DATA = 32'h55AA_55AA;
      @(negedge clk);
      bus0.iIO_REQ = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_busy", bus0.oIO_BUSY, 1'b0);
      check("midrst_valid", bus0.oIO_VALID, 1'b0);
      @(negedge clk);
      check("midrst_no_commit", flat0, '0);
      check("midrst_valid_late", bus0.oIO_VALID, 1'b0);

      // LATENCY=1 instance: write, then a held read that re-accepts every 2 cycles.
      @(negedge clk);
      bus1.iIO_REQ = 1'b1; bus1.iIO_ORDER = 2'b10; bus1.iIO_RW = 1'b0;
      bus1.iIO_ADDR = 32'h108; bus1.iIO_DATA = 32'h0BAD_F00D;
      @(negedge clk);
      bus1.iIO_REQ = 1'b0;
      check("l1_busy_resp", bus1.oIO_BUSY, 1'b1);
      check("l1_write_no_valid", bus1.oIO_VALID, 1'b0);
      @(negedge clk);
      check("l1_busy_done", bus1.oIO_BUSY, 1'b0);
      check("l1_reg2", flat1[95:64], 32'h0BAD_F00D);
      bus1.iIO_REQ = 1'b1; bus1.iIO_RW = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("l1_valid", bus1.oIO_VALID, (c % 2) == 1);
         check("l1_busy", bus1.oIO_BUSY, (c % 2) == 1);
         check("l1_data", bus1.oIO_DATA, ((c % 2) == 1) ? 32'h0BAD_F00D : 32'h0);
         @(negedge clk);
      end
      bus1.iIO_REQ = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("l1_idle", bus1.oIO_BUSY, 1'b0);

      // Random accesses against the model.
      for (int i = 0; i < 80; i++) begin
         r_ord = 2'($urandom_range(0, 3));
         r_rw  = 1'($urandom_range(0, 1));
         pick  = $urandom_range(0, 9);
         if (pick < 8)       r_addr = BASE + $urandom_range(0, 39);
         else if (pick == 8) r_addr = $urandom_range(0, 255);
         else                r_addr = 32'hFFFF_FF00 + $urandom_range(0, 255);
         if (r_ord == 2'b11 && $urandom_range(0, 1) == 1) r_ord = 2'b10;
         do_access(r_ord, r_rw, r_addr, $urandom(), $urandom_range(0, 7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
